// File: rtl/prot_fault_sequencer.sv
// Protection-fault sequencer: latches the highest-priority limit fault, flushes, then reports it.
// Optional build macro PROT_FAULT_COUNT_EN adds a saturating accepted-fault counter output.
module prot_fault_sequencer #(
    parameter logic [7:0]  GP_VECTOR    = 8'd13,
    parameter logic [7:0]  SS_VECTOR    = 8'd12,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op0_fault,
    input  logic        op1_fault,
    input  logic [31:0] op0_addr,
    input  logic [31:0] op1_addr,
    input  logic [2:0]  op0_seg,
    input  logic [2:0]  op1_seg,
    input  logic        stk_fault,
    input  logic [31:0] stk_addr,
    input  logic        stage_valid,
    input  logic [31:0] stage_eip,
    output logic        stall,
    output logic        flush,
    output logic        exc_valid,
    output logic [7:0]  exc_vector,
    output logic [31:0] exc_eip,
    output logic [31:0] exc_addr,
    output logic [2:0]  exc_seg,
    input  logic        exc_ack
`ifdef PROT_FAULT_COUNT_EN
    ,
    output logic [15:0] fault_count
`endif
);

    // state  | meaning
    // IDLE   | waiting for a valid faulting instruction
    // FLUSH  | squashing younger stages for FLUSH_CYCLES cycles
    // REPORT | exception presented to the interrupt unit until exc_ack
    typedef enum logic [1:0] {IDLE, FLUSH, REPORT} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [2:0] SS_SEG     = 3'd2;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  vec_q, vec_d;
    logic [31:0] eip_q, eip_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  seg_q, seg_d;
    logic        accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        eip_d     = eip_q;
        addr_d    = addr_q;
        seg_d     = seg_q;
        accept    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        exc_valid = 1'b0;
        // Reset silences the outputs in the same cycle, even with a fault on the inputs.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (stage_valid && (op0_fault || op1_fault || stk_fault)) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                        eip_d   = stage_eip;
                        if (op0_fault) begin
                            vec_d  = GP_VECTOR;
                            addr_d = op0_addr;
                            seg_d  = op0_seg;
                        end else if (op1_fault) begin
                            vec_d  = GP_VECTOR;
                            addr_d = op1_addr;
                            seg_d  = op1_seg;
                        end else begin
                            vec_d  = SS_VECTOR;
                            addr_d = stk_addr;
                            seg_d  = SS_SEG;
                        end
                    end
                end
                FLUSH: begin
                    stall = 1'b1;
                    flush = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = REPORT;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                REPORT: begin
                    stall     = 1'b1;
                    exc_valid = 1'b1;
                    if (exc_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            vec_q   <= 8'd0;
            eip_q   <= 32'd0;
            addr_q  <= 32'd0;
            seg_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            eip_q   <= eip_d;
            addr_q  <= addr_d;
            seg_q   <= seg_d;
        end
    end

    assign exc_vector = vec_q;
    assign exc_eip    = eip_q;
    assign exc_addr   = addr_q;
    assign exc_seg    = seg_q;

`ifdef PROT_FAULT_COUNT_EN
    logic [15:0] fault_count_q, fault_count_d;

    always_comb begin
        fault_count_d = fault_count_q;
        if (accept && (fault_count_q != 16'hFFFF)) begin
            fault_count_d = fault_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_count_q <= 16'd0;
        end else begin
            fault_count_q <= fault_count_d;
        end
    end

    assign fault_count = fault_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
